// File: rtl/run_controller_pkg.sv
// Shared state encoding and button indices for the run/pause/halt controller.
// The 2-bit state values are also what main's debug view decodes.
package run_controller_pkg;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        BUSY   = 2'd1,
        PAUSED = 2'd2,
        HALTED = 2'd3
    } run_state_t;

    localparam int NUM_BUTTONS = 4;
    localparam int BTN_START   = 0;
    localparam int BTN_INT     = 1;
    localparam int BTN_CLR     = 2;
    localparam int BTN_STEP    = 3;

endpackage

// File: rtl/run_controller_button_conditioner.sv
// Synchronises one raw push button, debounces it and emits a one-cycle
// registered pulse when the accepted level rises.
module button_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int DB_WIDTH  = 5
) (
    input  logic fpgaclock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

    logic                sync_a;
    logic                sync_b;
    logic                level;
    logic [DB_WIDTH-1:0] count;

    // count holds how many consecutive synchronised samples disagreed with level
    always_ff @(posedge fpgaclock) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == DB_LAST) begin
                level <= sync_b;
                count <= '0;
                pulse <= sync_b;
            end else begin
                count <= count + DB_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/pause/halt controller: conditions the four buttons and produces the
// clock-enable tick and clear pulse for main, plus a half-rate VGA enable.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int DIV_WIDTH = 21,
    parameter int DB_CYCLES = 16,
    parameter int DB_WIDTH  = 5
) (
    input  logic       fpgaclock,
    input  logic       reset,
    input  logic       start,
    input  logic       interrupt,
    input  logic       clear,
    input  logic       step,
    input  logic       halted,
    output logic       tick_en,
    output logic       main_clr,
    output logic       vga_en,
    output logic       ready,
    output logic       busy,
    output logic       interrupted,
    output logic       stopped,
    output logic [1:0] debug_state
);

    logic [NUM_BUTTONS-1:0] raw_buttons;
    logic [NUM_BUTTONS-1:0] pulses;
    logic                   start_p;
    logic                   int_p;
    logic                   clr_p;
    logic                   step_p;

    run_state_t             state;
    run_state_t             state_next;
    logic [DIV_WIDTH-1:0]   divider;
    logic [DIV_WIDTH-1:0]   divider_next;
    logic                   vga_phase;

    assign raw_buttons[BTN_START] = start;
    assign raw_buttons[BTN_INT]   = interrupt;
    assign raw_buttons[BTN_CLR]   = clear;
    assign raw_buttons[BTN_STEP]  = step;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_conditioner #(
            .DB_CYCLES(DB_CYCLES),
            .DB_WIDTH (DB_WIDTH)
        ) u_btn (
            .fpgaclock(fpgaclock),
            .reset    (reset),
            .raw      (raw_buttons[i]),
            .pulse    (pulses[i])
        );
    end

    assign start_p = pulses[BTN_START];
    assign int_p   = pulses[BTN_INT];
    assign clr_p   = pulses[BTN_CLR];
    assign step_p  = pulses[BTN_STEP];

    always_ff @(posedge fpgaclock) begin
        if (!reset) begin
            state     <= READY;
            divider   <= '0;
            vga_phase <= 1'b0;
        end else begin
            state     <= state_next;
            divider   <= divider_next;
            vga_phase <= ~vga_phase;
        end
    end

    // Priority within each state: clr_p > int_p > halted > step_p > start_p
    always_comb begin
        state_next   = state;
        divider_next = divider;
        tick_en      = 1'b0;
        main_clr     = 1'b0;
        case (state)
            READY: begin
                if (clr_p) begin
                    main_clr = 1'b1;
                end else if (start_p) begin
                    state_next   = BUSY;
                    divider_next = '0;
                end
            end
            BUSY: begin
                if (clr_p) begin
                    state_next = READY;
                    main_clr   = 1'b1;
                end else if (int_p) begin
                    state_next = PAUSED;
                end else if (halted) begin
                    state_next = HALTED;
                end else begin
                    divider_next = divider + DIV_WIDTH'(1);
                    tick_en      = &divider;
                end
            end
            PAUSED: begin
                if (clr_p) begin
                    state_next = READY;
                    main_clr   = 1'b1;
                end else if (int_p) begin
                    state_next = BUSY;
                end else if (!halted && step_p) begin
                    tick_en = 1'b1;
                end
            end
            HALTED: begin
                if (clr_p || start_p) begin
                    state_next = READY;
                    main_clr   = 1'b1;
                end
            end
            default: begin
                state_next = READY;
            end
        endcase
    end

    assign vga_en      = vga_phase;
    assign ready       = (state == READY);
    assign busy        = (state == BUSY);
    assign interrupted = (state == PAUSED);
    assign stopped     = (state == HALTED);
    assign debug_state = state;

endmodule
